// File: rtl/ycr1_wb_sram_slv.sv
// Wishbone slave bridging single-beat requests onto a 1-cycle-latency SRAM macro.
// Registered ack/err/data; optional extra wait states after each access.
module ycr1_wb_sram_slv #(
  parameter int MEM_AW   = 9,
  parameter int WAIT_CYC = 0
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              wbs_stb_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [3:0]        wbs_sel_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic              mem_csb_o,
  output logic              mem_web_o,
  output logic [3:0]        mem_wmask_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  input  logic [31:0]       mem_dout_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_WAIT,
    S_CAPT,
    S_RESP
  } state_t;

  localparam logic [1:0] WLOAD =
    (WAIT_CYC > 0) ? 2'(WAIT_CYC - 1) : 2'd0;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] adr_q, adr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        sel_q, sel_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              in_rng;
  logic              mem_act;

  assign in_rng = (wbs_adr_i[31:MEM_AW+2] == '0)
               && (wbs_adr_i[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wbs_stb_i) begin
          if (in_rng) begin
            we_d    = wbs_we_i;
            adr_d   = wbs_adr_i[MEM_AW+1:2];
            wdat_d  = wbs_dat_i;
            sel_d   = wbs_sel_i;
            state_d = S_MEM;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_MEM: begin
        if (WAIT_CYC != 0) begin
          cnt_d   = WLOAD;
          state_d = S_WAIT;
        end else if (we_q) begin
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_CAPT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (we_q) begin
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        rdat_d  = mem_dout_i;
        ack_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= 32'h0;
      sel_q   <= 4'h0;
      cnt_q   <= 2'd0;
      rdat_q  <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // SRAM pins are decoded from state so a reset drops them instantly
  assign mem_act     = (state_q == S_MEM);
  assign mem_csb_o   = ~mem_act;
  assign mem_web_o   = ~(mem_act & we_q);
  assign mem_wmask_o = (mem_act & we_q) ? sel_q : 4'h0;
  assign mem_addr_o  = adr_q;
  assign mem_din_o   = wdat_q;

  assign wbs_dat_o = rdat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;

endmodule
